// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter direction path.
// The counter uses the same DIR_ encoding, so both ends stay in step.
package updown_pkg;

    localparam logic DIR_UP         = 1'b0;
    localparam logic DIR_DOWN       = 1'b1;
    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    typedef enum logic {
        ST_UP   = DIR_UP,
        ST_DOWN = DIR_DOWN
    } dir_state_t;

    // Momentary mode follows the level outright.
    // Toggle mode flips only on a debounced rising edge.
    function automatic dir_state_t next_dir(
        input logic       mode,
        input logic       level,
        input logic       rise,
        input dir_state_t cur
    );
        dir_state_t nxt;
        if (mode == MODE_MOMENTARY) begin
            nxt = level ? ST_DOWN : ST_UP;
        end else if (rise) begin
            nxt = (cur == ST_UP) ? ST_DOWN : ST_UP;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer.
// Usable for any asynchronous push-button input.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic Reset,
    input  logic raw_in,
    output logic level_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            // Any sample that agrees with the current level restarts the run.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_out = r_level;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction control for the up/down counter: debounced button drives Down
// in toggle or momentary mode, with a one-cycle pulse on each change.
module updown_dir_ctrl
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic Reset,
    input  logic btn_dir,
    input  logic mode,
    output logic Down,
    output logic dir_pulse,
    output logic btn_level
);

    logic       w_level;
    logic       w_rise;
    dir_state_t w_next;
    logic       r_level_d;
    dir_state_t r_state;
    logic       r_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock     (clock),
        .Reset     (Reset),
        .raw_in    (btn_dir),
        .level_out (w_level)
    );

    assign w_rise = w_level & ~r_level_d;
    assign w_next = next_dir(mode, w_level, w_rise, r_state);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_level_d <= 1'b0;
            r_state   <= ST_UP;
            r_pulse   <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_state   <= w_next;
            r_pulse   <= (w_next != r_state);
        end
    end

    assign Down      = (r_state == ST_DOWN);
    assign dir_pulse = r_pulse;
    assign btn_level = w_level;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: per-cycle comparison against a window-based
// reference model, plus directed literal checks of the key latencies.
module tb_updown_dir_ctrl;

    localparam int DEB = 4;
    localparam int HIST = DEB + 4;

    logic clock = 1'b0;
    logic Reset = 1'b1;
    logic btn_dir = 1'b0;
    logic mode = 1'b0;
    logic Down, dir_pulse, btn_level;

    int n_vec = 0;
    int n_err = 0;

    updown_dir_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock     (clock),
        .Reset     (Reset),
        .btn_dir   (btn_dir),
        .mode      (mode),
        .Down      (Down),
        .dir_pulse (dir_pulse),
        .btn_level (btn_level)
    );

    always #5 clock = ~clock;

    // Reference model: raw_hist[k] is the button as sampled k edges ago.
    // The synchronised value seen at an edge is the raw sample two edges
    // earlier; the level flips once the last DEB of those all disagree with it.
    logic raw_hist [0:HIST-1];
    logic m_level, m_level_d, m_down, m_pulse;

    always @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < HIST; k++) raw_hist[k] = 1'b0;
            m_level = 0; m_level_d = 0; m_down = 0; m_pulse = 0;
        end else begin
            logic all_diff, rise, nd, new_level;
            for (int k = HIST - 1; k > 0; k--) raw_hist[k] = raw_hist[k-1];
            raw_hist[0] = btn_dir;
            all_diff = 1'b1;
            for (int k = 2; k < 2 + DEB; k++)
                if (raw_hist[k] == m_level) all_diff = 1'b0;
            new_level = all_diff ? ~m_level : m_level;
            rise = m_level & ~m_level_d;
            if (mode) nd = m_level;
            else      nd = rise ? ~m_down : m_down;
            m_pulse   = (nd != m_down);
            m_down    = nd;
            m_level_d = m_level;
            m_level   = new_level;
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp, input bit verbose);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end else if (verbose) begin
            $display("vec %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("down_vs_model",  Down,      m_down,  1'b0);
        chk("pulse_vs_model", dir_pulse, m_pulse, 1'b0);
        chk("level_vs_model", btn_level, m_level, 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #1;
        chk("reset_down", Down, 1'b0, 1'b1);
        chk("reset_pulse", dir_pulse, 1'b0, 1'b1);
        tick(3);
        Reset = 1'b0;

        // 1: idle after reset
        tick(3);
        chk("t1_down", Down, 1'b0, 1'b1);
        chk("t1_level", btn_level, 1'b0, 1'b1);

        // 2: clean press in toggle mode
        btn_dir = 1'b1;
        tick(5);
        chk("t2_level_e5", btn_level, 1'b0, 1'b1);
        tick(1);
        chk("t2_level_e6", btn_level, 1'b1, 1'b1);
        chk("t2_down_e6", Down, 1'b0, 1'b1);
        tick(1);
        chk("t2_down_e7", Down, 1'b1, 1'b1);
        chk("t2_pulse_e7", dir_pulse, 1'b1, 1'b1);
        tick(1);
        chk("t2_pulse_e8", dir_pulse, 1'b0, 1'b1);
        tick(12);
        btn_dir = 1'b0;
        tick(20);
        chk("t2_release_down", Down, 1'b1, 1'b1);
        chk("t2_release_level", btn_level, 1'b0, 1'b1);
        btn_dir = 1'b1;
        tick(7);
        chk("t2_second_down", Down, 1'b0, 1'b1);
        chk("t2_second_pulse", dir_pulse, 1'b1, 1'b1);
        tick(13);
        btn_dir = 1'b0;
        tick(10);

        // 3: bounce 1,0,1,1,0,1 then stable high
        begin
            logic [5:0] pat;
            pat = 6'b101101;
            for (int i = 5; i >= 0; i--) begin
                btn_dir = pat[i];
                tick(1);
            end
        end
        btn_dir = 1'b1;
        tick(4);
        chk("t3_level_e10", btn_level, 1'b0, 1'b1);
        tick(1);
        chk("t3_level_e11", btn_level, 1'b1, 1'b1);
        tick(1);
        chk("t3_down_e12", Down, 1'b1, 1'b1);
        chk("t3_pulse_e12", dir_pulse, 1'b1, 1'b1);
        tick(5);
        btn_dir = 1'b0;
        tick(10);

        // 4: three-clock glitch must be rejected
        btn_dir = 1'b1;
        tick(3);
        btn_dir = 1'b0;
        tick(10);
        chk("t4_level", btn_level, 1'b0, 1'b1);
        chk("t4_down", Down, 1'b1, 1'b1);

        // bring Down back to 0 in toggle mode
        btn_dir = 1'b1;
        tick(10);
        btn_dir = 1'b0;
        tick(10);
        chk("t5_pre_down", Down, 1'b0, 1'b1);

        // 5: momentary mode
        mode = 1'b1;
        tick(3);
        btn_dir = 1'b1;
        tick(7);
        chk("t5_down_held", Down, 1'b1, 1'b1);
        chk("t5_pulse_held", dir_pulse, 1'b1, 1'b1);
        tick(3);
        btn_dir = 1'b0;
        tick(6);
        chk("t5_down_e6_rel", Down, 1'b1, 1'b1);
        tick(1);
        chk("t5_down_e7_rel", Down, 1'b0, 1'b1);
        chk("t5_pulse_e7_rel", dir_pulse, 1'b1, 1'b1);
        tick(3);
        mode = 1'b0;
        tick(3);
        chk("t5_back_toggle", Down, 1'b0, 1'b1);

        // 6: async reset with Down = 1 and a partial debounce count
        btn_dir = 1'b1;
        tick(10);
        btn_dir = 1'b0;
        tick(10);
        btn_dir = 1'b1;
        tick(4);
        chk("t6_pre_down", Down, 1'b1, 1'b1);
        #3 Reset = 1'b1;
        #1;
        chk("t6_async_down", Down, 1'b0, 1'b1);
        chk("t6_async_level", btn_level, 1'b0, 1'b1);
        chk("t6_async_pulse", dir_pulse, 1'b0, 1'b1);
        @(posedge clock);
        #1 Reset = 1'b0;
        tick(5);
        chk("t6_level_e5", btn_level, 1'b0, 1'b1);
        tick(1);
        chk("t6_level_e6", btn_level, 1'b1, 1'b1);
        tick(1);
        chk("t6_down_e7", Down, 1'b1, 1'b1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
